image_rank_filter: RTL and testbench
====================================

Name: image_rank_filter

Overview:
- Parametrised 3x3 rank filter for the ISP video path.
- Successor to the fixed 8-bit 3x3 median stage. Adds a generic pixel width, internal line buffers sized by line width, and a run-time mode select: median, min (erode), max (dilate) or bypass.
- Sits between a streaming video source (hsync/vsync/de plus pixel) and downstream ISP stages. Sync signals are delayed to match the pixel latency.

Parameters:
- DATA_W, 8: pixel width in bits.
- IMG_W, 1280: active pixels per line; sets line-buffer depth.
- LAT, 4: fixed pipeline latency in clocks. Derived constant, not overridable in use.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- hsync_i  in  1  input line sync.
- vsync_i  in  1  input frame sync, active high.
- de_i  in  1  input data enable.
- data_i  in  DATA_W  input pixel.
- mode_i  in  2  filter mode: 00 median, 01 min, 10 max, 11 bypass.
- hsync_o  out  1  hsync_i delayed by LAT.
- vsync_o  out  1  vsync_i delayed by LAT.
- de_o  out  1  de_i delayed by LAT.
- data_o  out  DATA_W  filtered pixel.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset state: all outputs 0; sync delay lines 0; column and row counters 0; mode register 00 (median); window registers 0. Line-buffer contents are not reset.
- Line buffers:
  - Two cascaded buffers, IMG_W deep, DATA_W wide.
  - Written and advanced only when de_i=1. Idle cycles hold contents.
  - Window rows: top = buffer 2 output, middle = buffer 1 output, bottom = data_i.
  - Each row is shifted into a 3-tap register when de_i=1.
- Counters:
  - col_cnt increments on each de_i=1 cycle and clears on the de_i falling edge.
  - row_cnt increments on each de_i falling edge and clears on the vsync_i rising edge.
  - Both saturate: col at IMG_W-1, row at 2047.
- Mode latch: mode_i is sampled into mode_q only on the vsync_i rising edge. A mid-frame change takes effect from the next frame.
- Pipeline stages:
  - S1: window register.
  - S2: per-row 3-sort (max/mid/min), registered.
  - S3: column reduce, registered:
    - min-of-maxes, mid-of-mids, max-of-mins (median path);
    - min-of-mins (min path);
    - max-of-maxes (max path).
  - S4: median = mid of the three S3 median values; registered output mux by mode_q.
- Bypass path: the newest window pixel, delayed to the same latency.
- Latency: exactly LAT=4 clocks from de_i to de_o and from the newest window pixel to data_o. The output is not spatially recentred; the downstream stage handles the one-line, one-pixel offset.
- data_o when de_o=0: drives 0.
- Comparisons: unsigned, DATA_W bits. Ties are stable (equal values pass unchanged); no arithmetic, no overflow.
- Stalls: when de_i=0 mid-line, the window does not advance. Output sync still tracks the input exactly.
- Reset mid-frame: everything returns to the reset state at once. The first complete frame after the next vsync_i rising edge is valid.
- vsync_i asserted with de_i=1: row_cnt clears and mode_q updates in the same cycle. The pixel is still processed.

Optional Feature:
- Macro: IMAGE_RANK_BORDER_EN.
- Defined: a window is "incomplete" when row_cnt<2 or col_cnt<2 at S1. For incomplete windows the output is forced to the bypass pixel regardless of mode_q. The border flag is pipelined alongside the data.
- Undefined: no border detection. Incomplete windows use stale line-buffer or window contents (0 after reset) and the filter result is output as computed.

Decomposition:
- Package image_rank_pkg:
  - mode localparams MODE_MED=2'b00, MODE_MIN=2'b01, MODE_MAX=2'b10, MODE_BYP=2'b11;
  - RANK_LAT=4.
- Sub-module rank_sort3: registered 3-input unsigned sorter, parameter DATA_W, outputs max/mid/min, asynchronous active-low reset. Used in S2 and for the S3/S4 reductions.
- Line buffer: inline shift-register/RAM inference in the top module; no separate module.

Test Plan (DATA_W=8, IMG_W=8):
- Flat frame, all pixels 0x40, mode 00 → every de_o pixel 0x40 after line 2. de_o/hsync_o/vsync_o equal the inputs delayed exactly 4 clocks.
- Flat 0x10 frame with one 0xFF impulse at row 4, col 4, mode 00 → 0xFF never appears on data_o; all outputs 0x10.
- Same impulse, mode 10 (max) → exactly nine output pixels equal 0xFF, forming a 3x3 block. Mode 01 (min) → all outputs 0x10.
- mode_i changes 00→10 mid-frame → median output continues to frame end; max output starts with the first pixel of the next frame.
- rst_n pulsed low mid-line → all outputs 0 during reset; the next frame after vsync with a flat value of 0x80 outputs 0x80 from row 2.
- With IMAGE_RANK_BORDER_EN, ramp frame pixel=row*8+col, mode 01 → rows 0-1 and cols 0-1 output the raw pixel. Interior outputs equal the window minimum; the first interior output equals 0x00 (window rows 0-2, cols 0-2).

Source files
------------

// File: rtl/image_rank_pkg.sv
// Shared constants for the 3x3 rank filter: run-time mode encodings and pipeline latency.
package image_rank_pkg;

  localparam logic [1:0] MODE_MED = 2'b00;
  localparam logic [1:0] MODE_MIN = 2'b01;
  localparam logic [1:0] MODE_MAX = 2'b10;
  localparam logic [1:0] MODE_BYP = 2'b11;

  localparam int RANK_LAT = 4;

endpackage

// File: rtl/rank_sort3.sv
// Registered unsigned 3-input sorter; ties pass through unchanged.
module rank_sort3 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  output logic [DATA_W-1:0] max_val,
  output logic [DATA_W-1:0] mid_val,
  output logic [DATA_W-1:0] min_val
);

  logic [DATA_W-1:0] hi_ab_s;
  logic [DATA_W-1:0] lo_ab_s;
  logic [DATA_W-1:0] max_s;
  logic [DATA_W-1:0] mid_s;
  logic [DATA_W-1:0] min_s;

  // Compare network: order a/b, then place c relative to that pair.
  always_comb begin
    hi_ab_s = (a >= b) ? a : b;
    lo_ab_s = (a >= b) ? b : a;
    max_s   = (hi_ab_s >= c) ? hi_ab_s : c;
    min_s   = (lo_ab_s <= c) ? lo_ab_s : c;
    if (c >= hi_ab_s) begin
      mid_s = hi_ab_s;
    end else if (c <= lo_ab_s) begin
      mid_s = lo_ab_s;
    end else begin
      mid_s = c;
    end
  end

  // Result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_val <= {DATA_W{1'b0}};
      mid_val <= {DATA_W{1'b0}};
      min_val <= {DATA_W{1'b0}};
    end else begin
      max_val <= max_s;
      mid_val <= mid_s;
      min_val <= min_s;
    end
  end

endmodule

// File: rtl/image_rank_filter.sv
// 3x3 median/min/max/bypass rank filter with internal line buffers and matched sync delay.
// Define IMAGE_RANK_BORDER_EN to force the bypass pixel for windows touching row/col 0-1.
module image_rank_filter
  import image_rank_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 1280
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hsync_i,
  input  logic              vsync_i,
  input  logic              de_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        mode_i,
  output logic              hsync_o,
  output logic              vsync_o,
  output logic              de_o,
  output logic [DATA_W-1:0] data_o
);

  localparam int                LAT     = RANK_LAT;
  localparam int                PTR_W   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [PTR_W-1:0]  PTR_MAX = PTR_W'(IMG_W - 1);
  localparam logic [10:0]       ROW_MAX = 11'd2047;
  localparam logic [DATA_W-1:0] PIX_Z   = {DATA_W{1'b0}};

  logic [LAT-1:0]    hs_dly_r, vs_dly_r, de_dly_r;
  logic              de_fall_s, vs_rise_s;
  logic [PTR_W-1:0]  ptr_r, col_cnt_r;
  logic [10:0]       row_cnt_r;
  logic [1:0]        mode_r;
  logic [DATA_W-1:0] lb1_mem [IMG_W];
  logic [DATA_W-1:0] lb2_mem [IMG_W];
  logic [DATA_W-1:0] row_mid_s, row_top_s;
  logic [2:0][2:0][DATA_W-1:0] win_r;
  logic [DATA_W-1:0] byp2_r, byp3_r;
  logic              use_byp_s;

  assign de_fall_s = de_dly_r[0] & ~de_i;
  assign vs_rise_s = vsync_i & ~vs_dly_r[0];
  assign hsync_o   = hs_dly_r[LAT-1];
  assign vsync_o   = vs_dly_r[LAT-1];
  assign de_o      = de_dly_r[LAT-1];

  // Sync delay lines matching the pixel pipeline depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_dly_r <= {LAT{1'b0}};
      vs_dly_r <= {LAT{1'b0}};
      de_dly_r <= {LAT{1'b0}};
    end else begin
      hs_dly_r <= {hs_dly_r[LAT-2:0], hsync_i};
      vs_dly_r <= {vs_dly_r[LAT-2:0], vsync_i};
      de_dly_r <= {de_dly_r[LAT-2:0], de_i};
    end
  end

  // Column/row position and per-frame mode latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt_r <= {PTR_W{1'b0}};
      row_cnt_r <= 11'd0;
      mode_r    <= MODE_MED;
    end else begin
      if (de_i) begin
        if (col_cnt_r != PTR_MAX) col_cnt_r <= col_cnt_r + PTR_W'(1);
      end else if (de_fall_s) begin
        col_cnt_r <= {PTR_W{1'b0}};
      end
      if (vs_rise_s) begin
        row_cnt_r <= 11'd0;
      end else if (de_fall_s && (row_cnt_r != ROW_MAX)) begin
        row_cnt_r <= row_cnt_r + 11'd1;
      end
      if (vs_rise_s) mode_r <= mode_i;
    end
  end

  // Circular line-buffer address; advances with accepted pixels only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= {PTR_W{1'b0}};
    end else if (de_i) begin
      ptr_r <= (ptr_r == PTR_MAX) ? {PTR_W{1'b0}} : ptr_r + PTR_W'(1);
    end
  end

  assign row_mid_s = lb1_mem[ptr_r];
  assign row_top_s = lb2_mem[ptr_r];

  // Cascaded line buffers: read-before-write at the same address yields the pixel one line back.
  always_ff @(posedge clk) begin
    if (de_i) begin
      lb1_mem[ptr_r] <= data_i;
      lb2_mem[ptr_r] <= row_mid_s;
    end
  end

  // S1 window: row 0 top, row 2 bottom; tap 0 is the newest column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_r <= {(9*DATA_W){1'b0}};
    end else if (de_i) begin
      win_r[0] <= {win_r[0][1:0], row_top_s};
      win_r[1] <= {win_r[1][1:0], row_mid_s};
      win_r[2] <= {win_r[2][1:0], data_i};
    end
  end

`ifdef IMAGE_RANK_BORDER_EN
  logic brd1_r, brd2_r, brd3_r;

  // Incomplete-window flag, travelling with the data through S1..S3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brd1_r <= 1'b0;
      brd2_r <= 1'b0;
      brd3_r <= 1'b0;
    end else begin
      if (de_i) brd1_r <= (row_cnt_r < 11'd2) || (col_cnt_r < PTR_W'(2));
      brd2_r <= brd1_r;
      brd3_r <= brd2_r;
    end
  end

  assign use_byp_s = brd3_r;
`else
  logic unused_cnt_s;
  assign unused_cnt_s = ^{col_cnt_r, row_cnt_r};
  assign use_byp_s    = 1'b0;
`endif

  // Bypass pixel aligned with S2/S3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp2_r <= PIX_Z;
      byp3_r <= PIX_Z;
    end else begin
      byp2_r <= win_r[2][0];
      byp3_r <= byp2_r;
    end
  end

  // S2: per-row sort.
  logic [DATA_W-1:0] row_max_s [3];
  logic [DATA_W-1:0] row_mid_v_s [3];
  logic [DATA_W-1:0] row_min_s [3];

  for (genvar g = 0; g < 3; g++) begin : g_row_sort
    rank_sort3 #(.DATA_W(DATA_W)) u_row (
      .clk(clk), .rst_n(rst_n),
      .a(win_r[g][0]), .b(win_r[g][1]), .c(win_r[g][2]),
      .max_val(row_max_s[g]), .mid_val(row_mid_v_s[g]), .min_val(row_min_s[g])
    );
  end

  // S3: column reductions.
  logic [DATA_W-1:0] max_of_max_s, min_of_max_s, mid_of_mid_s, max_of_min_s, min_of_min_s;
  logic [DATA_W-1:0] unused_a_mid_s, unused_b_max_s, unused_b_min_s, unused_c_mid_s;

  rank_sort3 #(.DATA_W(DATA_W)) u_col_max (
    .clk(clk), .rst_n(rst_n),
    .a(row_max_s[0]), .b(row_max_s[1]), .c(row_max_s[2]),
    .max_val(max_of_max_s), .mid_val(unused_a_mid_s), .min_val(min_of_max_s)
  );
  rank_sort3 #(.DATA_W(DATA_W)) u_col_mid (
    .clk(clk), .rst_n(rst_n),
    .a(row_mid_v_s[0]), .b(row_mid_v_s[1]), .c(row_mid_v_s[2]),
    .max_val(unused_b_max_s), .mid_val(mid_of_mid_s), .min_val(unused_b_min_s)
  );
  rank_sort3 #(.DATA_W(DATA_W)) u_col_min (
    .clk(clk), .rst_n(rst_n),
    .a(row_min_s[0]), .b(row_min_s[1]), .c(row_min_s[2]),
    .max_val(max_of_min_s), .mid_val(unused_c_mid_s), .min_val(min_of_min_s)
  );

  // S4 operand select: the final sorter's mid output is the registered, mode-muxed pixel.
  logic [DATA_W-1:0] s4_a_s, s4_b_s, s4_c_s;

  always_comb begin
    s4_a_s = PIX_Z;
    s4_b_s = PIX_Z;
    s4_c_s = PIX_Z;
    if (!de_dly_r[2]) begin
      s4_a_s = PIX_Z;
    end else if (use_byp_s) begin
      s4_a_s = byp3_r;
      s4_b_s = byp3_r;
      s4_c_s = byp3_r;
    end else begin
      case (mode_r)
        MODE_MED: begin
          s4_a_s = min_of_max_s;
          s4_b_s = mid_of_mid_s;
          s4_c_s = max_of_min_s;
        end
        MODE_MIN: begin
          s4_a_s = min_of_min_s;
          s4_b_s = min_of_min_s;
          s4_c_s = min_of_min_s;
        end
        MODE_MAX: begin
          s4_a_s = max_of_max_s;
          s4_b_s = max_of_max_s;
          s4_c_s = max_of_max_s;
        end
        default: begin
          s4_a_s = byp3_r;
          s4_b_s = byp3_r;
          s4_c_s = byp3_r;
        end
      endcase
    end
  end

  logic [DATA_W-1:0] unused_d_max_s, unused_d_min_s;

  rank_sort3 #(.DATA_W(DATA_W)) u_out (
    .clk(clk), .rst_n(rst_n),
    .a(s4_a_s), .b(s4_b_s), .c(s4_c_s),
    .max_val(unused_d_max_s), .mid_val(data_o), .min_val(unused_d_min_s)
  );

endmodule

// File: tb/tb_image_rank_filter.sv
// Self-checking bench for image_rank_filter (DATA_W=8, IMG_W=8, 8-line frames).
module tb_image_rank_filter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hsync_i, vsync_i, de_i;
  logic [7:0] data_i;
  logic [1:0] mode_i;
  logic       hsync_o, vsync_o, de_o;
  logic [7:0] data_o;

  image_rank_filter #(.DATA_W(8), .IMG_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .hsync_i(hsync_i), .vsync_i(vsync_i), .de_i(de_i), .data_i(data_i), .mode_i(mode_i),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o), .data_o(data_o)
  );

  always #5 clk = ~clk;

`ifdef IMAGE_RANK_BORDER_EN
  localparam int STALL = 0;
`else
  localparam int STALL = 20;
`endif

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [7:0] d;
    logic       chk;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] img [8][8];
  logic [1:0] frame_mode;
  int         n_vec = 0;
  int         n_err = 0;
  int         ff_cnt = 0;

  // Reference: sort the nine window pixels of the current frame and pick by rank.
  function automatic logic [7:0] ref_pix(input int r, input int c, input logic [1:0] md);
    logic [7:0] v [9];
    logic [7:0] t;
    int n = 0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++) begin
        v[n] = img[r-2+dr][c-2+dc];
        n++;
      end
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8 - i; j++)
        if (v[j] > v[j+1]) begin
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
        end
    case (md)
      2'b00:   return v[4];
      2'b01:   return v[0];
      2'b10:   return v[8];
      default: return img[r][c];
    endcase
  endfunction

  task automatic chk1(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_vec++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic prefill();
    exp_t z;
    z = '0;
    z.chk = 1'b1;
    repeat (3) exp_q.push_back(z);
  endtask

  // One clock: drive inputs, queue their expectation, compare the output due from 4 clocks ago.
  task automatic step(input logic hs, input logic vs, input logic de, input logic [7:0] d,
                      input int r, input int c);
    exp_t e;
    hsync_i = hs; vsync_i = vs; de_i = de; data_i = d;
    e.hs = hs; e.vs = vs; e.de = de; e.d = 8'h00; e.chk = 1'b1;
    if (de) begin
      if (r < 0) e.chk = 1'b0;
      else if (r >= 2 && c >= 2) e.d = ref_pix(r, c, frame_mode);
      else begin
`ifdef IMAGE_RANK_BORDER_EN
        e.d = img[r][c];
`else
        e.chk = 1'b0;
`endif
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk1("hsync_o", {7'd0, hsync_o}, {7'd0, e.hs});
    chk1("vsync_o", {7'd0, vsync_o}, {7'd0, e.vs});
    chk1("de_o", {7'd0, de_o}, {7'd0, e.de});
    if (e.chk) chk1("data_o", data_o, e.d);
    if (de_o === 1'b1 && data_o === 8'hFF) ff_cnt++;
  endtask

  task automatic blank(input logic hs, input logic vs);
    step(hs, vs, 1'b0, 8'($urandom), -1, -1);
  endtask

  task automatic run_frame(input logic [1:0] md, input logic [1:0] md_mid, input int stall_pct);
    mode_i = md;
    frame_mode = md;
    blank(1'b0, 1'b0); blank(1'b0, 1'b0);
    blank(1'b0, 1'b1); blank(1'b0, 1'b1);
    blank(1'b0, 1'b0);
    for (int r = 0; r < 8; r++) begin
      blank(1'b1, 1'b0); blank(1'b0, 1'b0);
      for (int c = 0; c < 8; c++) begin
        if (c > 0 && $urandom_range(0, 99) < stall_pct) blank(1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, img[r][c], r, c);
      end
      if (r == 3) mode_i = md_mid;
    end
    repeat (5) blank(1'b0, 1'b0);
  endtask

  task automatic fill_flat(input logic [7:0] v);
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) img[r][c] = v;
  endtask

  task automatic fill_rand();
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) img[r][c] = 8'($urandom);
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) img[r][c] = 8'(r * 8 + c);
  endtask

  initial begin
    rst_n = 1'b0; hsync_i = 1'b0; vsync_i = 1'b0; de_i = 1'b0; data_i = 8'h00;
    mode_i = 2'b00; frame_mode = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_hsync_o", {7'd0, hsync_o}, 8'h00);
    chk1("rst_vsync_o", {7'd0, vsync_o}, 8'h00);
    chk1("rst_de_o", {7'd0, de_o}, 8'h00);
    chk1("rst_data_o", data_o, 8'h00);
    rst_n = 1'b1;
    prefill();

    fill_flat(8'h40);
    run_frame(2'b00, 2'b00, STALL);
    run_frame(2'b00, 2'b00, STALL);

    fill_flat(8'h10);
    img[4][4] = 8'hFF;
    ff_cnt = 0;
    run_frame(2'b00, 2'b00, STALL);
    chk1("impulse_med_ff_count", 8'(ff_cnt), 8'd0);
    ff_cnt = 0;
    run_frame(2'b10, 2'b10, STALL);
    chk1("impulse_max_ff_count", 8'(ff_cnt), 8'd9);
    ff_cnt = 0;
    run_frame(2'b01, 2'b01, STALL);
    chk1("impulse_min_ff_count", 8'(ff_cnt), 8'd0);

    fill_rand();
    run_frame(2'b00, 2'b10, STALL);
    fill_rand();
    run_frame(2'b10, 2'b10, STALL);

    for (int k = 0; k < 4; k++) begin
      logic [1:0] md;
      md = 2'($urandom_range(0, 3));
      fill_rand();
      run_frame(md, md, STALL);
    end

    mode_i = 2'b11;
    frame_mode = 2'b11;
    blank(1'b0, 1'b1); blank(1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b1, 8'($urandom), -1, -1);
    rst_n = 1'b0; hsync_i = 1'b1; vsync_i = 1'b1; de_i = 1'b1; data_i = 8'hA5;
    #1;
    chk1("midrst_hsync_o", {7'd0, hsync_o}, 8'h00);
    chk1("midrst_vsync_o", {7'd0, vsync_o}, 8'h00);
    chk1("midrst_de_o", {7'd0, de_o}, 8'h00);
    chk1("midrst_data_o", data_o, 8'h00);
    @(posedge clk);
    #1;
    chk1("midrst_de_o_held", {7'd0, de_o}, 8'h00);
    chk1("midrst_data_o_held", data_o, 8'h00);
    hsync_i = 1'b0; vsync_i = 1'b0; de_i = 1'b0; data_i = 8'h00;
    rst_n = 1'b1;
    exp_q.delete();
    prefill();
    fill_flat(8'h80);
    run_frame(2'b10, 2'b10, STALL);

    fill_ramp();
    run_frame(2'b01, 2'b01, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
